// File: rtl/fill_span_writer.sv
// Writes one horizontal span of pixels into the frame buffer, then answers the
// fill controller with a one-cycle fill_done and waits for the request to drop.
module fill_span_writer #(
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               fill_start,
    input  logic [X_W-1:0]     x_left,
    input  logic [X_W-1:0]     x_right,
    input  logic [Y_W-1:0]     row_y,
    input  logic [COLOR_W-1:0] color,
    input  logic               fb_ready,
    output logic               fb_wr,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fill_done,
    output logic               busy
);

    typedef enum logic [2:0] {StIdle, StSetup, StWrite, StDone, StRelease} state_e;

    localparam logic [X_W-1:0] XMax = X_W'(SCREEN_W - 1);

    state_e state_q, state_d;

    logic [X_W-1:0]     lo_q, hi_q, x_q;
    logic [Y_W-1:0]     row_q;
    logic [COLOR_W-1:0] color_q;
    logic [ADDR_W-1:0]  base_q;
    logic               last_pix;
    logic               empty_span;

    assign last_pix   = (x_q == hi_q);
    assign empty_span = (lo_q > XMax);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (fill_start) state_d = StSetup;
            StSetup:   state_d = empty_span ? StDone : StWrite;
            StWrite:   if (fb_ready && last_pix) state_d = StDone;
            StDone:    state_d = StRelease;
            StRelease: if (!fill_start) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Span registers: bounds are ordered at capture, clamped and converted to a
    // row base address during SETUP, then x walks lo..hi on each accepted write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lo_q    <= '0;
            hi_q    <= '0;
            x_q     <= '0;
            row_q   <= '0;
            color_q <= '0;
            base_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fill_start) begin
                        lo_q    <= (x_left <= x_right) ? x_left : x_right;
                        hi_q    <= (x_left <= x_right) ? x_right : x_left;
                        row_q   <= row_y;
                        color_q <= color;
                    end
                end
                StSetup: begin
                    if (hi_q > XMax) hi_q <= XMax;
                    base_q <= ADDR_W'(row_q) * ADDR_W'(SCREEN_W);
                    x_q    <= lo_q;
                end
                StWrite: begin
                    if (fb_ready && !last_pix) x_q <= x_q + X_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fb_wr     = (state_q == StWrite);
        fill_done = (state_q == StDone);
        busy      = (state_q != StIdle);
        fb_addr   = base_q + ADDR_W'(x_q);
        fb_data   = color_q;
    end

endmodule

// File: tb/tb_fill_span_writer.sv
// Directed bench for fill_span_writer: a span-level scoreboard predicts every
// frame-buffer write and a negedge monitor checks each accepted write against it.
module tb_fill_span_writer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        fill_start;
    logic [9:0]  x_left, x_right;
    logic [8:0]  row_y;
    logic [7:0]  color;
    logic        fb_ready;
    logic        fb_wr;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fill_done;
    logic        busy;

    fill_span_writer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .fill_start (fill_start),
        .x_left     (x_left),
        .x_right    (x_right),
        .row_y      (row_y),
        .color      (color),
        .fb_ready   (fb_ready),
        .fb_wr      (fb_wr),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fill_done  (fill_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  acc_log[$];
    int  tests = 0;
    int  fails = 0;
    int  writes_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected writes of one span: ordered bounds, right edge clipped to the screen.
    task automatic model_span(input int xl, input int xr, input int y, input int c);
        int lo, hi;
        lo = (xl < xr) ? xl : xr;
        hi = (xl < xr) ? xr : xl;
        if (hi > 639) hi = 639;
        for (int x = lo; x <= hi; x++) exp_q.push_back('{y * 640 + x, c});
    endtask

    logic        prev_stall = 1'b0;
    logic [18:0] prev_addr  = '0;
    wr_t         cmp_e;

    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (prev_stall) begin
                chk("hold_wr", {31'd0, fb_wr}, 32'd1);
                chk("hold_addr", {13'd0, fb_addr}, {13'd0, prev_addr});
            end
            if (fb_wr && fb_ready) begin
                writes_seen++;
                acc_log.push_back(int'(fb_addr));
                if (exp_q.size() == 0) begin
                    chk("extra_write", {13'd0, fb_addr}, 32'hFFFF_FFFF);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("wr_addr", {13'd0, fb_addr}, cmp_e.addr);
                    chk("wr_data", {24'd0, fb_data}, cmp_e.data);
                end
            end
            if (fill_done) chk("done_after_last", exp_q.size(), 0);
            prev_stall = fb_wr && !fb_ready;
            prev_addr  = fb_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_span(input int xl, input int xr, input int y, input int c,
                           input logic [31:0] stall, input int hold,
                           output int done_cyc, output int nwr);
        int w0;
        @(posedge clk); #1;
        x_left = 10'(xl); x_right = 10'(xr); row_y = 9'(y); color = 8'(c);
        fill_start = 1'b1;
        fb_ready   = 1'b1;
        model_span(xl, xr, y, c);
        w0 = writes_seen;
        done_cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            fb_ready = (k < 32) ? !stall[k] : 1'b1;
            if (k == 2) begin
                x_left  = 10'($urandom);
                x_right = 10'($urandom);
                row_y   = 9'($urandom);
                color   = 8'($urandom);
            end
            @(negedge clk);
            if (k == 1) chk("busy_setup", {31'd0, busy}, 32'd1);
            if (fill_done) begin
                done_cyc = k;
                break;
            end
        end
        if (done_cyc == 0) chk("done_timeout", {31'd0, fill_done}, 32'd1);
        @(posedge clk); #1;
        fb_ready = 1'b1;
        chk("done_one_cycle", {31'd0, fill_done}, 32'd0);
        chk("busy_release", {31'd0, busy}, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("busy_hold", {31'd0, busy}, 32'd1);
            chk("no_retrigger_wr", {31'd0, fb_wr}, 32'd0);
        end
        fill_start = 1'b0;
        @(posedge clk); #1;
        chk("busy_idle", {31'd0, busy}, 32'd0);
        nwr = writes_seen - w0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d, n, w0;
        n_rst = 1'b0; fill_start = 1'b0; fb_ready = 1'b1;
        x_left = '0; x_right = '0; row_y = '0; color = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr", {31'd0, fb_wr}, 32'd0);
        chk("rst_done", {31'd0, fill_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {13'd0, fb_addr}, 32'd0);
        chk("rst_data", {24'd0, fb_data}, 32'd0);
        n_rst = 1'b1;

        acc_log.delete();
        do_span(5, 5, 0, 'hAA, 32'd0, 0, d, n);
        chk("single_writes", n, 1);
        chk("single_done_cyc", d, 3);
        chk("single_addr_lit", acc_log[0], 5);

        acc_log.delete();
        do_span(12, 10, 2, 'h33, 32'd0, 0, d, n);
        chk("swap_writes", n, 3);
        chk("swap_done_cyc", d, 5);
        chk("swap_addr0_lit", acc_log[0], 1290);
        chk("swap_addr2_lit", acc_log[2], 1292);

        acc_log.delete();
        do_span(0, 3, 1, 'h5C, 32'h0000_0038, 0, d, n);
        chk("bp_writes", n, 4);
        chk("bp_done_cyc", d, 9);
        chk("bp_addr1_lit", acc_log[1], 641);

        acc_log.delete();
        do_span(638, 700, 479, 'h77, 32'd0, 0, d, n);
        chk("clamp_writes", n, 2);
        chk("clamp_done_cyc", d, 4);
        chk("clamp_last_lit", acc_log[1], 307199);

        do_span(650, 660, 479, 'h77, 32'd0, 0, d, n);
        chk("empty_writes", n, 0);
        chk("empty_done_cyc", d, 2);

        do_span(100, 101, 7, 'h11, 32'd0, 1, d, n);
        chk("hs_writes", n, 2);
        chk("hs_done_cyc", d, 4);
        w0 = writes_seen;
        repeat (5) @(posedge clk);
        #1;
        chk("hs_no_second_span", writes_seen - w0, 0);
        chk("hs_idle", {31'd0, busy}, 32'd0);

        // Reset lands while the third pixel of a ten-pixel span is on the port.
        @(posedge clk); #1;
        x_left = 10'd20; x_right = 10'd29; row_y = 9'd3; color = 8'h3C;
        fill_start = 1'b1;
        model_span(20, 29, 3, 'h3C);
        w0 = writes_seen;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_addr", {13'd0, fb_addr}, 32'd1942);
        chk("rst_mid_wr", {31'd0, fb_wr}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_wr_off", {31'd0, fb_wr}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_addr0", {13'd0, fb_addr}, 32'd0);
        chk("rst_mid_count", writes_seen - w0, 2);
        exp_q.delete();
        fill_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        w0 = writes_seen;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_writes", writes_seen - w0, 0);
        chk("rst_idle", {31'd0, busy}, 32'd0);

        acc_log.delete();
        do_span(300, 304, 10, 'hE1, 32'd0, 0, d, n);
        chk("after_rst_writes", n, 5);
        chk("after_rst_addr_lit", acc_log[0], 6700);

        chk("model_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
